// File: rtl/sparhixcel_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sparhixcel_loader_pkg
// Brief    : Shared types and constants for the sparhixcel stream loader:
//            target encoding, header field layout, FSM states, and the
//            signal-ROM geometry shared with the array top.
// Revision : 1.0 - initial release
// ============================================================================
package sparhixcel_loader_pkg;

  // Destination selected by the header word
  typedef enum logic [1:0] {
    TGT_FEAT    = 2'd0,
    TGT_WEIGHT  = 2'd1,
    TGT_ROM     = 2'd2,
    TGT_INVALID = 2'd3
  } target_e;

  // Header word layout: target, base address, payload length in words
  localparam int HDR_TGT_LSB  = 0;
  localparam int HDR_TGT_W    = 2;
  localparam int HDR_BASE_LSB = 2;
  localparam int HDR_BASE_W   = 16;
  localparam int HDR_LEN_LSB  = 18;
  localparam int HDR_LEN_W    = 16;
  localparam int HDR_W        = 34;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Geometry shared with the array top
  localparam int N_ROWS_C        = 16;
  localparam int SIG_ROW_BITS_C  = 9;
  localparam int ROM_SIG_WIDTH_C = SIG_ROW_BITS_C * N_ROWS_C;
  localparam int SIG_DEPTH_C     = 18;

  // Header field extraction helpers
  function automatic target_e hdr_target(input logic [HDR_W-1:0] h);
    return target_e'(h[HDR_TGT_LSB +: HDR_TGT_W]);
  endfunction

  function automatic logic [HDR_BASE_W-1:0] hdr_base(input logic [HDR_W-1:0] h);
    return h[HDR_BASE_LSB +: HDR_BASE_W];
  endfunction

  function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [HDR_W-1:0] h);
    return h[HDR_LEN_LSB +: HDR_LEN_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sparhixcel_loader_wr_port.sv
`default_nettype none
// ============================================================================
// Module   : loader_wr_port
// Brief    : Registered write-port slice: one-cycle strobe per request,
//            address and data captured on the request and held afterwards.
// Revision : 1.0 - initial release
// ============================================================================
module loader_wr_port #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ld,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Register the write request; strobe follows the request for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld   <= 1'b0;
      addr <= '0;
      data <= '0;
    end else begin
      ld <= we;
      if (we) begin
        addr <= addr_in;
        data <= data_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sparhixcel_loader.sv
`default_nettype none
// ============================================================================
// Module   : sparhixcel_loader
// Brief    : Stream loader: a header word selects a target memory, base
//            address and length; the following payload words are written
//            one per cycle to the feature, weight or signal-ROM port.
// Revision : 1.0 - initial release
// ============================================================================
module sparhixcel_loader
  import sparhixcel_loader_pkg::*;
#(
  parameter int N_ROWS_ARRAY    = N_ROWS_C,
  parameter int I_WIDTH         = 8,
  parameter int F_WIDTH         = 8,
  parameter int ROM_SIG_WIDTH   = ROM_SIG_WIDTH_C,
  parameter int FEAT_ADDR_WIDTH = 16,
  parameter int SIG_ADDR_WIDTH  = 5,
  parameter int SIG_DEPTH       = SIG_DEPTH_C,
  parameter int DATA_WIDTH      = ROM_SIG_WIDTH
) (
  input  logic                              clk_i,
  input  logic                              general_rst_ni,
  input  logic                              clear_i,
  input  logic                              s_valid_i,
  output logic                              s_ready_o,
  input  logic [DATA_WIDTH-1:0]             s_data_i,
  output logic [N_ROWS_ARRAY*I_WIDTH-1:0]   mem_data_o,
  output logic [FEAT_ADDR_WIDTH-1:0]        wr_addrs_mem_o,
  output logic                              wr_mem_ld_o,
  output logic [N_ROWS_ARRAY*F_WIDTH-1:0]   mem2_data_o,
  output logic [FEAT_ADDR_WIDTH-1:0]        wr_addrs_mem2_o,
  output logic                              wr_mem2_ld_o,
  output logic [ROM_SIG_WIDTH-1:0]          rom_signals_data_o,
  output logic [SIG_ADDR_WIDTH-1:0]         wr_addrs_rom_signal_o,
  output logic                              wr_rom_signals_ld_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o
);

  localparam int MEM_W  = N_ROWS_ARRAY * I_WIDTH;
  localparam int MEM2_W = N_ROWS_ARRAY * F_WIDTH;
  localparam int FULL_W = HDR_BASE_W + 1;
  // base+k is compared at one bit wider than the base so it never wraps
  localparam logic [FULL_W-1:0] SIG_LIMIT = FULL_W'(SIG_DEPTH);

  state_e                 state;
  target_e                target;
  logic [HDR_BASE_W-1:0]  base;
  logic [HDR_LEN_W-1:0]   len;
  logic [HDR_LEN_W-1:0]   count;
  logic                   busy;
  logic                   done;
  logic                   err;

  logic                       accept;
  logic                       beat;
  logic                       last_beat;
  logic                       rom_in_range;
  logic                       beat_err;
  logic                       we_mem;
  logic                       we_mem2;
  logic                       we_rom;
  logic [FULL_W-1:0]          full_addr;
  logic [FEAT_ADDR_WIDTH-1:0] feat_addr;
  logic [HDR_W-1:0]           hdr_word;
  target_e                    new_target;
  logic [HDR_BASE_W-1:0]      new_base;
  logic [HDR_LEN_W-1:0]       new_len;
  logic [MEM_W-1:0]           mem_data_in;
  logic [MEM2_W-1:0]          mem2_data_in;
  logic [ROM_SIG_WIDTH-1:0]   rom_data_in;

  assign s_ready_o = ((state == ST_IDLE) || (state == ST_LOAD)) && !clear_i;
  assign accept    = s_valid_i && s_ready_o;
  assign beat      = accept && (state == ST_LOAD);
  assign last_beat = (count == (len - HDR_LEN_W'(1)));

  assign hdr_word   = s_data_i[HDR_W-1:0];
  assign new_target = hdr_target(hdr_word);
  assign new_base   = hdr_base(hdr_word);
  assign new_len    = hdr_len(hdr_word);

  // Feature/weight addresses wrap naturally at the port width
  assign feat_addr    = FEAT_ADDR_WIDTH'(base) + FEAT_ADDR_WIDTH'(count);
  assign full_addr    = {1'b0, base} + {1'b0, count};
  assign rom_in_range = (full_addr < SIG_LIMIT);

  assign we_mem   = beat && (target == TGT_FEAT);
  assign we_mem2  = beat && (target == TGT_WEIGHT);
  assign we_rom   = beat && (target == TGT_ROM) && rom_in_range;
  assign beat_err = beat && (((target == TGT_ROM) && !rom_in_range) ||
                             (target == TGT_INVALID));

  assign mem_data_in  = MEM_W'(s_data_i);
  assign mem2_data_in = MEM2_W'(s_data_i);
  assign rom_data_in  = ROM_SIG_WIDTH'(s_data_i);

  // Transfer FSM with registered status outputs and sticky error flag
  always_ff @(posedge clk_i or negedge general_rst_ni) begin
    if (!general_rst_ni) begin
      state  <= ST_IDLE;
      target <= TGT_FEAT;
      base   <= '0;
      len    <= '0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else if (clear_i) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            target <= new_target;
            base   <= new_base;
            len    <= new_len;
            count  <= '0;
            err    <= 1'b0;
            busy   <= 1'b1;
            if (new_len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (beat) begin
            count <= count + HDR_LEN_W'(1);
            if (beat_err) err <= 1'b1;
            if (last_beat) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy;
  assign done_o = done;
  assign err_o  = err;

  loader_wr_port #(.DATA_W(MEM_W), .ADDR_W(FEAT_ADDR_WIDTH)) u_mem_port (
    .clk     (clk_i),
    .rst_n   (general_rst_ni),
    .we      (we_mem),
    .addr_in (feat_addr),
    .data_in (mem_data_in),
    .ld      (wr_mem_ld_o),
    .addr    (wr_addrs_mem_o),
    .data    (mem_data_o)
  );

  loader_wr_port #(.DATA_W(MEM2_W), .ADDR_W(FEAT_ADDR_WIDTH)) u_mem2_port (
    .clk     (clk_i),
    .rst_n   (general_rst_ni),
    .we      (we_mem2),
    .addr_in (feat_addr),
    .data_in (mem2_data_in),
    .ld      (wr_mem2_ld_o),
    .addr    (wr_addrs_mem2_o),
    .data    (mem2_data_o)
  );

  loader_wr_port #(.DATA_W(ROM_SIG_WIDTH), .ADDR_W(SIG_ADDR_WIDTH)) u_rom_port (
    .clk     (clk_i),
    .rst_n   (general_rst_ni),
    .we      (we_rom),
    .addr_in (SIG_ADDR_WIDTH'(full_addr)),
    .data_in (rom_data_in),
    .ld      (wr_rom_signals_ld_o),
    .addr    (wr_addrs_rom_signal_o),
    .data    (rom_signals_data_o)
  );

endmodule
`default_nettype wire

// File: doc/sparhixcel_loader.md
SPARHIXCEL_LOADER -- requirements
Module: sparhixcel_loader

Interface
REQ-001 SHALL have parameter N_ROWS_ARRAY, default 16: rows fed per memory word.
REQ-002 SHALL have parameter I_WIDTH, default 8, and F_WIDTH, default 8: feature and weight element widths.
REQ-003 SHALL have parameter ROM_SIG_WIDTH, default 144: signal-ROM word width (9 bits x 16 rows).
REQ-004 SHALL have parameter FEAT_ADDR_WIDTH, default 16, and SIG_ADDR_WIDTH, default 5; SIG_DEPTH, default 18: signal-ROM entries.
REQ-005 SHALL have parameter DATA_WIDTH, default ROM_SIG_WIDTH: stream word width (>= N_ROWS_ARRAY*I_WIDTH, >= 34).
REQ-006 clk_i  input  1  single clock, rising edge.
REQ-007 general_rst_ni  input  1  asynchronous active-low reset.
REQ-008 clear_i  input  1  synchronous abort to IDLE.
REQ-009 s_valid_i / s_ready_o  input / output  1 / 1  stream handshake.
REQ-010 s_data_i  input  DATA_WIDTH  header or payload word.
REQ-011 mem_data_o, wr_addrs_mem_o, wr_mem_ld_o  output  N_ROWS_ARRAY*I_WIDTH / FEAT_ADDR_WIDTH / 1  feature-memory write port.
REQ-012 mem2_data_o, wr_addrs_mem2_o, wr_mem2_ld_o  output  N_ROWS_ARRAY*F_WIDTH / FEAT_ADDR_WIDTH / 1  weight-memory write port.
REQ-013 rom_signals_data_o, wr_addrs_rom_signal_o, wr_rom_signals_ld_o  output  ROM_SIG_WIDTH / SIG_ADDR_WIDTH / 1  signal-ROM write port.
REQ-014 busy_o, done_o, err_o  output  1 each  transfer active, one-cycle completion pulse, sticky error.

Function
REQ-015 Header word fields SHALL be: target = s_data_i[1:0] (0 feature, 1 weight, 2 signal ROM, 3 invalid), base = [17:2], length = [33:18] words.
REQ-016 FSM states SHALL be IDLE, LOAD, DONE; IDLE->LOAD on header beat with length != 0; IDLE->DONE on header beat with length == 0; LOAD->DONE on acceptance of the last payload beat; DONE->IDLE unconditionally after one cycle.
REQ-017 A beat SHALL be accepted only when s_valid_i && s_ready_o; s_ready_o = (state is IDLE or LOAD) && !clear_i.
REQ-018 Payload beat k (0-based) accepted in cycle t SHALL raise exactly one write strobe in cycle t+1 with address base+k and data from the low bits of s_data_i.
REQ-019 Data and address outputs SHALL be registered; strobes SHALL be high for exactly one cycle per accepted beat, allowing one write per cycle.
REQ-020 Feature/weight addresses SHALL wrap modulo 2^FEAT_ADDR_WIDTH without error.
REQ-021 Signal-ROM beats with base+k >= SIG_DEPTH SHALL be consumed with no strobe, and SHALL set err_o.
REQ-022 Target 3 SHALL consume its payload with no strobes, and SHALL set err_o.
REQ-023 done_o SHALL be high exactly in the DONE cycle; busy_o SHALL be high in LOAD and DONE.
REQ-024 err_o SHALL stay set until reset or until the next accepted header, which clears it.
REQ-025 clear_i SHALL force IDLE on the next edge, suppress acceptance in its cycle, emit no done_o, and leave err_o unchanged; a strobe from a beat accepted in the previous cycle SHALL still complete.
REQ-026 s_ready_o SHALL be low in DONE, so a new header is never accepted in the completion cycle.

Reset
REQ-027 Asserting general_rst_ni low SHALL immediately force: state IDLE, all strobes 0, all addresses 0, all data outputs 0, busy_o/done_o/err_o 0, internal counters 0.
REQ-028 Reset SHALL abort a transfer mid-payload; no strobe SHALL occur during reset or in the first cycle after release.

Structure
REQ-029 The shared package SHALL hold the target encoding enum, the header field positions, the FSM state typedef, and the SIG_DEPTH/width constants that are shared with the array top.
REQ-030 The block SHALL be one module; the only sub-block SHALL be a write-port register slice (loader_wr_port) instantiated three times.

Verification
REQ-031 Header target=0 base=0x00FE len=3, then 3 beats back-to-back -> wr_mem_ld_o high 3 consecutive cycles at 0x00FE,0x00FF,0x0100, then done_o one cycle.
REQ-032 Header target=0 base=0xFFFF len=2 -> writes at 0xFFFF then 0x0000, err_o stays 0.
REQ-033 Header target=2 base=16 len=4 -> ROM strobes only at 16,17; all 4 beats accepted; err_o=1 after the third beat.
REQ-034 Header target=1 len=0 -> no strobes, done_o one cycle after the header, and s_ready_o low in that cycle.
REQ-035 Weight transfer len=5 with s_valid_i toggling every cycle, then clear_i after beat 2 -> exactly 2 wr_mem2_ld_o pulses, IDLE, no done_o.
REQ-036 general_rst_ni pulsed low mid-payload -> all outputs 0 asynchronously; a new header then completes normally.
